// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath mux and enable.
// Latency: outputs are a decode of the current state (plus mem_ready in FETCH,
// and opcode for illegal), so they settle in the same cycle as the state.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while mem_ready is low.
//
// Parameters:
//   MEM_WAIT_EN_DEFAULT  1: honour mem_ready; 0: treat mem_ready as always 1.
// Optional feature macro: MC_PERF_COUNTERS_EN enables the cycle and
//   instruction counters; when undefined both counter ports read 0.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   opcode              IR[31:26], valid from DECODE onward
//   mem_ready           memory completes the current access this cycle
//   pc_write .. pc_source  datapath mux selects and write enables
//   illegal             one-cycle pulse in DECODE for an unsupported opcode
//   state               current state, for debug
//   cycle_count, instr_count  performance counters

module multi_cycle_control #(
   parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t cur;
   state_t nxt;
   logic   rdy;
   logic   op_legal;

   assign rdy = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;

   assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                     (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                     (opcode == OP_J)     || (opcode == OP_ADDI);

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:     nxt = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      nxt = S_EXECUTE;
               OP_LW, OP_SW:  nxt = S_MEM_ADDR;
               OP_BEQ:        nxt = S_BRANCH;
               OP_J:          nxt = S_JUMP;
               OP_ADDI:       nxt = S_ADDI_EXEC;
               default:       nxt = S_FETCH;
            endcase
         end
         // IR still holds the instruction, so the opcode picks load vs store.
         S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  nxt = rdy ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    nxt = S_FETCH;
         S_MEM_WRITE: nxt = rdy ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   nxt = S_R_WB;
         S_R_WB:      nxt = S_FETCH;
         S_BRANCH:    nxt = S_FETCH;
         S_JUMP:      nxt = S_FETCH;
         S_ADDI_EXEC: nxt = S_ADDI_WB;
         S_ADDI_WB:   nxt = S_FETCH;
         default:     nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   assign state = cur;

   // Control decode. Everything is forced low while rst is high so that an
   // abandoned memory access does not keep strobing during reset.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal       = 1'b0;
      if (!rst) begin
         case (cur)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               // PC+4 and IR only commit on the cycle the fetch completes.
               ir_write  = rdy;
               pc_write  = rdy;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               illegal   = !op_legal;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
               reg_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MC_PERF_COUNTERS_EN
   logic [31:0] cycle_q;
   logic [31:0] instr_q;
   logic        instr_done;

   // An instruction retires on the transition back to FETCH from a
   // completing state; illegal opcodes return from DECODE and do not count.
   assign instr_done = (cur == S_MEM_WB) || (cur == S_R_WB) ||
                       (cur == S_BRANCH) || (cur == S_JUMP) ||
                       (cur == S_ADDI_WB) || ((cur == S_MEM_WRITE) && rdy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q <= 32'd0;
         instr_q <= 32'd0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (instr_done) instr_q <= instr_q + 32'd1;
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = 32'd0;
   assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic        mem_ready = 1'b1;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] cycle_count, instr_count;

   multi_cycle_control #(.MEM_WAIT_EN_DEFAULT(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal(illegal), .state(state),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

   int checks = 0;
   int errors = 0;
   int exp_cyc = 0;
   int exp_ins = 0;
   logic last_ir, last_mw;

   typedef struct {
      logic [5:0] op;
      int         len;
      int         tr[6];
      bit         counts;
   } vec_t;
   vec_t vecs[7];

   function automatic bit is_legal(input logic [5:0] op);
      return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
             op == OP_J || op == OP_ADDI;
   endfunction

   // Expected control outputs, transcribed from the per-state assertion list.
   // Packing: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
   //           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
   //           pc_source, illegal, state}
   function automatic logic [20:0] exp_vec(input int st, input logic rdy,
                                           input logic [5:0] op, input bit in_rst);
      logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
      logic rd = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 0, ao = 0, ps = 0;
      logic [3:0] s4 = st[3:0];
      if (in_rst) return 21'd0;
      case (st)
         0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
         1:  begin sb = 2'b11; ill = !is_legal(op); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iod = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
         9:  begin pw = 1; ps = 2'b10; end
         10: begin sa = 1; sb = 2'b10; end
         11: begin rw = 1; end
         default: ;
      endcase
      return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill, s4};
   endfunction

   function automatic logic [20:0] act_vec();
      return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, illegal, state};
   endfunction

   function automatic logic [31:0] perf(input int v);
`ifdef MC_PERF_COUNTERS_EN
      return v;
`else
      return 32'd0 + 0 * v;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   // One clock cycle: entered at posedge+1, drives inputs, checks at negedge,
   // returns at the next posedge+1 with the reference counters advanced.
   task automatic cyc(input logic [5:0] op, input logic rdy, input int exp_st,
                      input bit done, input string name);
      opcode = op;
      mem_ready = rdy;
      @(negedge clk);
      chk(name, {43'd0, act_vec()}, {43'd0, exp_vec(exp_st, rdy, op, 1'b0)});
      chk({name, "_cnt"}, {cycle_count, instr_count}, {perf(exp_cyc), perf(exp_ins)});
      last_ir = ir_write;
      last_mw = mem_write;
      @(posedge clk);
      #1;
      exp_cyc++;
      if (done) exp_ins++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = 6'd0;
      @(negedge clk);
      chk("reset_outputs", {43'd0, act_vec()}, 64'd0);
      chk("reset_counters", {cycle_count, instr_count}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cyc = 0;
      exp_ins = 0;
   endtask

   // Reference flow: the phases an instruction class walks through.
   function automatic void phases_for(input logic [5:0] op, output int q[$]);
      q = {0, 1};
      case (op)
         OP_R:    q = {q, 6, 7};
         OP_LW:   q = {q, 2, 3, 4};
         OP_SW:   q = {q, 2, 5};
         OP_BEQ:  q = {q, 8};
         OP_J:    q = {q, 9};
         OP_ADDI: q = {q, 10, 11};
         default: ;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int ir_pulses, mw_cycles, sw_cycles;
      int q[$];
      logic [5:0] rop;
      logic rr;
      bit pop_now;

      vecs[0].op = OP_R;    vecs[0].len = 4; vecs[0].tr = '{0, 1, 6, 7, 0, 0};  vecs[0].counts = 1;
      vecs[1].op = OP_BEQ;  vecs[1].len = 3; vecs[1].tr = '{0, 1, 8, 0, 0, 0};  vecs[1].counts = 1;
      vecs[2].op = OP_J;    vecs[2].len = 3; vecs[2].tr = '{0, 1, 9, 0, 0, 0};  vecs[2].counts = 1;
      vecs[3].op = OP_ADDI; vecs[3].len = 4; vecs[3].tr = '{0, 1, 10, 11, 0, 0}; vecs[3].counts = 1;
      vecs[4].op = OP_LW;   vecs[4].len = 5; vecs[4].tr = '{0, 1, 2, 3, 4, 0};  vecs[4].counts = 1;
      vecs[5].op = OP_SW;   vecs[5].len = 4; vecs[5].tr = '{0, 1, 2, 5, 0, 0};  vecs[5].counts = 1;
      vecs[6].op = 6'b111111; vecs[6].len = 2; vecs[6].tr = '{0, 1, 0, 0, 0, 0}; vecs[6].counts = 0;

      do_reset();

      // Table vectors at zero wait; R, beq, j, addi take 14 cycles in total.
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].len; i++)
            cyc(vecs[v].op, 1'b1, vecs[v].tr[i],
                vecs[v].counts && (i == vecs[v].len - 1), $sformatf("vec%0d_c%0d", v, i));
         if (v == 3) chk("perf_after_14", {cycle_count, instr_count}, {perf(14), perf(4)});
      end
      chk("illegal_no_count", {32'd0, instr_count}, {32'd0, perf(6)});

      // sw with three wait cycles in MEM_WRITE: CPI 7, mem_write for 4 cycles.
      mw_cycles = 0;
      sw_cycles = 0;
      cyc(OP_SW, 1'b1, 0, 0, "sw_f");   sw_cycles++;
      cyc(OP_SW, 1'b1, 1, 0, "sw_d");   sw_cycles++;
      cyc(OP_SW, 1'b1, 2, 0, "sw_a");   sw_cycles++;
      for (int i = 0; i < 4; i++) begin
         cyc(OP_SW, (i == 3), 5, (i == 3), $sformatf("sw_w%0d", i));
         sw_cycles++;
         if (last_mw) mw_cycles++;
      end
      chk("sw_mem_write_cycles", 64'(mw_cycles), 64'd4);
      chk("sw_cpi", 64'(sw_cycles), 64'd7);

      // FETCH stalled two cycles: ir_write pulses once, on the third cycle.
      ir_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(OP_J, (i == 2), 0, 0, $sformatf("fw_%0d", i));
         if (last_ir) ir_pulses++;
      end
      chk("fetch_ir_pulses", 64'(ir_pulses), 64'd1);
      chk("fetch_ir_last", {63'd0, last_ir}, 64'd1);
      cyc(OP_J, 1'b0, 1, 0, "fw_d");
      cyc(OP_J, 1'b0, 9, 1, "fw_j");

      // Reset while a load sits waiting in MEM_READ.
      cyc(OP_LW, 1'b1, 0, 0, "rl_f");
      cyc(OP_LW, 1'b1, 1, 0, "rl_d");
      cyc(OP_LW, 1'b1, 2, 0, "rl_a");
      cyc(OP_LW, 1'b0, 3, 0, "rl_r");
      opcode = OP_LW;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rl_wait", {43'd0, act_vec()}, {43'd0, exp_vec(3, 1'b0, OP_LW, 1'b0)});
      #2 rst = 1'b1;
      #1;
      chk("rl_async_reset", {43'd0, act_vec()}, 64'd0);
      chk("rl_reset_cnt", {cycle_count, instr_count}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cyc = 0;
      exp_ins = 0;
      cyc(OP_LW, 1'b1, 0, 0, "rl_refetch");
      cyc(OP_LW, 1'b1, 1, 0, "rl_d2");
      cyc(OP_LW, 1'b1, 2, 0, "rl_a2");
      cyc(OP_LW, 1'b1, 3, 0, "rl_r2");
      cyc(OP_LW, 1'b1, 4, 1, "rl_wb2");

      // Random instruction mix with random memory readiness.
      do_reset();
      rop = OP_R;
      for (int n = 0; n < 3000; n++) begin
         if (q.size() == 0) begin
            case ($urandom_range(0, 6))
               0: rop = OP_R;
               1: rop = OP_LW;
               2: rop = OP_SW;
               3: rop = OP_BEQ;
               4: rop = OP_J;
               5: rop = OP_ADDI;
               default: begin
                  rop = 6'($urandom_range(0, 63));
                  for (int k = 0; k < 16 && is_legal(rop); k++)
                     rop = 6'($urandom_range(0, 63));
                  if (is_legal(rop)) rop = 6'b111111;
               end
            endcase
            phases_for(rop, q);
         end
         rr = ($urandom_range(0, 3) != 0);
         pop_now = !((q[0] == 0 || q[0] == 3 || q[0] == 5) && !rr);
         cyc(rop, rr, q[0], pop_now && q.size() == 1 && is_legal(rop), "rand");
         if (pop_now) void'(q.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Moore-style main control FSM for the multi-cycle MIPS processor. It shares one memory, one ALU and the PC/IR registers across the phases of each instruction. It sequences fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake. It sits beside the multi-cycle datapath and drives every datapath mux and write enable. Opcode comes from the datapath's instruction register.

## Interface
Parameters:
- `MEM_WAIT_EN_DEFAULT`, default 1: when 0, `mem_ready` is ignored and treated as constant 1.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero.
- `i_or_d`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load.
- `mem_to_reg`  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- `reg_dst`  out  1  destination register: 1 = rd, 0 = rt.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  2  to alu_control: 00 = add, 01 = sub, 10 = funct.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- `state`  out  4  current state, for debug.
- `cycle_count`  out  32  performance counter (see Configuration).
- `instr_count`  out  32  performance counter (see Configuration).

## Operation
State encodings and per-state assertions (unlisted outputs are 0):
- FETCH=0: mem_read, alu_src_b=01; `ir_write`=`pc_write`=`mem_ready`.
- DECODE=1: alu_src_b=11. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 / 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - other → FETCH with `illegal`=1
- MEM_ADDR=2: alu_src_a, alu_src_b=10. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ=3: mem_read, i_or_d. Waits for `mem_ready`, then → MEM_WB.
- MEM_WB=4: reg_write, mem_to_reg. Next → FETCH.
- MEM_WRITE=5: mem_write, i_or_d. Waits for `mem_ready`, then → FETCH.
- EXECUTE=6: alu_src_a, alu_op=10. Next → R_WB.
- R_WB=7: reg_write, reg_dst. Next → FETCH.
- BRANCH=8: alu_src_a, alu_op=01, pc_write_cond, pc_source=01. Next → FETCH.
- JUMP=9: pc_write, pc_source=10. Next → FETCH.
- ADDI_EXEC=10: alu_src_a, alu_src_b=10. Next → ADDI_WB.
- ADDI_WB=11: reg_write. Next → FETCH.
- Encodings 12–15 are unreachable; if entered → FETCH, all outputs 0.

Wait-state and reset rules:
- Wait states (FETCH, MEM_READ, MEM_WRITE with `mem_ready`=0): state holds and outputs are stable. No `ir_write`/`pc_write` until the ready cycle.
- Reset: state=FETCH asynchronously. While `rst`=1 all control outputs and `illegal` are 0 and `state` reads 0. A memory access in flight is abandoned.

## Timing
- Cycles per instruction at zero wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Each cycle of `mem_ready`=0 in a memory state adds exactly one cycle.
- Outputs depend only on `state` and `mem_ready`, except `illegal`, which also depends on `opcode`.
- The first FETCH begins on the first posedge after `rst` deasserts.
- `mem_ready` asserted outside memory states is ignored.

## Configuration
- `MC_PERF_COUNTERS_EN` defined:
  - `cycle_count` increments every cycle while not in reset.
  - `instr_count` increments on every transition into FETCH from a completing state (MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB). Illegal opcodes are not counted.
  - Both counters wrap at 2^32 and are reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops.

## Test plan
- Reset asserted mid-MEM_READ → `state`=0 immediately, all controls 0. After release, FETCH with `mem_read`=1.
- lw with `mem_ready`=1 → states 0,1,2,3,4 then 0. `reg_write`=1 only in cycle 5; `instr_count` +1.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` held 4 cycles, then FETCH. CPI is 7.
- FETCH with `mem_ready` low for 2 cycles → `ir_write`/`pc_write` pulse once, on the third cycle only.
- Sequence R, beq, j, addi → state traces 0,1,6,7 / 0,1,8 / 0,1,9 / 0,1,10,11. After 14 cycles, `cycle_count`=14 and `instr_count`=4.
- opcode 111111 → `illegal`=1 for one cycle in DECODE, return to FETCH, `instr_count` unchanged.
